// File: rtl/fp_add_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fp_add_control
//  Purpose  : Sequencing FSM for the floating-point adder datapath. Drives
//             stage-0 mux selects, the pre-add shift amount and the pipeline
//             enables, then walks the sum through normalize/round with at most
//             one re-normalization pass. Classifies special operands and
//             produces registered Zero/Inf/Nan flags plus Done/Busy.
//  Revision : 1.0 - initial release
// ============================================================================
module fp_add_control #(
  parameter int EXPW     = 8,
  parameter int FRACW    = 23,
  parameter int MAXSHIFT = 26
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            Go,
  input  logic            SignA,
  input  logic            SignB,
  input  logic [EXPW-1:0] ExpA,
  input  logic [EXPW-1:0] ExpB,
  input  logic            FracANz,
  input  logic            FracBNz,
  input  logic            ExpSet,
  input  logic [EXPW-1:0] ExpDiff,
  input  logic            SumCarry,
  input  logic            SumZero,
  input  logic            RoundOvf,
  input  logic            ExpOvf,
  output logic            SelExpMux,
  output logic            SelSRMuxL,
  output logic            SelSRMuxG,
  output logic [5:0]      ShiftRightAmount,
  output logic            Pipe0En,
  output logic            Pipe1En,
  output logic            NormEn,
  output logic            SelManMuxR,
  output logic            SelExpMuxR,
  output logic            SREn,
  output logic            Busy,
  output logic            Done,
  output logic            Zero,
  output logic            Inf,
  output logic            Nan
);

  // Any shift past FRACW+3 already pushes the hidden bit into sticky, so the
  // saturation value never needs to exceed that.
  localparam int            c_SAT   = (MAXSHIFT < FRACW + 3) ? MAXSHIFT : FRACW + 3;
  localparam logic [EXPW-1:0] c_SAT_E = EXPW'(c_SAT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADD   = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;
  logic   r_renorm, w_renorm_nxt;
  logic   r_zero, r_inf, r_nan;
  logic   w_zero_nxt, w_inf_nxt, w_nan_nxt;

  // Operand classification (denormals are treated as zero)
  logic w_a_max, w_b_max, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic w_cls_nan, w_cls_inf, w_cls_zero, w_special;
  logic [5:0] w_shamt;

  assign w_a_max    = &ExpA;
  assign w_b_max    = &ExpB;
  assign w_a_nan    = w_a_max & FracANz;
  assign w_b_nan    = w_b_max & FracBNz;
  assign w_a_inf    = w_a_max & ~FracANz;
  assign w_b_inf    = w_b_max & ~FracBNz;
  assign w_a_zero   = (ExpA == '0);
  assign w_b_zero   = (ExpB == '0);
  assign w_cls_nan  = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (SignA ^ SignB));
  assign w_cls_inf  = ~w_cls_nan & (w_a_inf | w_b_inf);
  assign w_cls_zero = ~w_cls_nan & ~w_cls_inf & w_a_zero & w_b_zero;
  assign w_special  = w_cls_nan | w_cls_inf | w_cls_zero;
  assign w_shamt    = (ExpDiff > c_SAT_E) ? 6'(c_SAT) : 6'(ExpDiff);

  assign Busy = (r_state != S_IDLE);
  assign Done = (r_state == S_DONE);
  assign Zero = r_zero;
  assign Inf  = r_inf;
  assign Nan  = r_nan;

  // State, renorm flag and result flags
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= S_IDLE;
      r_renorm <= 1'b0;
      r_zero   <= 1'b0;
      r_inf    <= 1'b0;
      r_nan    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_renorm <= w_renorm_nxt;
      r_zero   <= w_zero_nxt;
      r_inf    <= w_inf_nxt;
      r_nan    <= w_nan_nxt;
    end
  end

  // Next-state, datapath controls and flag updates
  always_comb begin
    w_state_nxt      = r_state;
    w_renorm_nxt     = r_renorm;
    w_zero_nxt       = r_zero;
    w_inf_nxt        = r_inf;
    w_nan_nxt        = r_nan;
    SelExpMux        = 1'b0;
    SelSRMuxL        = 1'b0;
    SelSRMuxG        = 1'b0;
    ShiftRightAmount = '0;
    Pipe0En          = 1'b0;
    Pipe1En          = 1'b0;
    NormEn           = 1'b0;
    SelManMuxR       = 1'b0;
    SelExpMuxR       = 1'b0;
    SREn             = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Go) begin
          Pipe0En          = 1'b1;
          SelExpMux        = ExpSet;
          SelSRMuxG        = ExpSet;
          SelSRMuxL        = ~ExpSet;
          ShiftRightAmount = w_shamt;
          w_renorm_nxt     = 1'b0;
          w_zero_nxt       = w_cls_zero;
          w_inf_nxt        = w_cls_inf;
          w_nan_nxt        = w_cls_nan;
          w_state_nxt      = w_special ? S_DONE : S_ADD;
        end
      end
      S_ADD: begin
        Pipe1En     = 1'b1;
        w_state_nxt = S_NORM;
      end
      S_NORM: begin
        NormEn = 1'b1;
        if (r_renorm) begin
          // Rounding carried out: mantissa is 2.x, always shift right by one
          SREn        = 1'b1;
          w_state_nxt = S_ROUND;
        end else begin
          SREn = SumCarry;
          if (SumZero) begin
            w_zero_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ROUND;
          end
        end
      end
      S_ROUND: begin
        if (ExpOvf) begin
          w_inf_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (RoundOvf && !r_renorm) begin
          w_renorm_nxt = 1'b1;
          SelManMuxR   = 1'b1;
          SelExpMuxR   = 1'b1;
          Pipe1En      = 1'b1;
          w_state_nxt  = S_NORM;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_add_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fp_add_control
//  Purpose  : Self-checking bench for fp_add_control: table of whole
//             operations plus hand sequences for renorm, Go-while-busy,
//             reset mid-operation and back-to-back throughput.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_add_control;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Go = 1'b0;
  logic       SignA = 1'b0, SignB = 1'b0;
  logic [7:0] ExpA = '0, ExpB = '0, ExpDiff = '0;
  logic       FracANz = 1'b0, FracBNz = 1'b0, ExpSet = 1'b0;
  logic       SumCarry = 1'b0, SumZero = 1'b0, RoundOvf = 1'b0, ExpOvf = 1'b0;
  logic       SelExpMux, SelSRMuxL, SelSRMuxG;
  logic [5:0] ShiftRightAmount;
  logic       Pipe0En, Pipe1En, NormEn, SelManMuxR, SelExpMuxR, SREn;
  logic       Busy, Done, Zero, Inf, Nan;

  int n_cmp = 0;
  int n_err = 0;

  fp_add_control #(.EXPW(8), .FRACW(23), .MAXSHIFT(26)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Go(Go),
    .SignA(SignA), .SignB(SignB), .ExpA(ExpA), .ExpB(ExpB),
    .FracANz(FracANz), .FracBNz(FracBNz), .ExpSet(ExpSet), .ExpDiff(ExpDiff),
    .SumCarry(SumCarry), .SumZero(SumZero), .RoundOvf(RoundOvf), .ExpOvf(ExpOvf),
    .SelExpMux(SelExpMux), .SelSRMuxL(SelSRMuxL), .SelSRMuxG(SelSRMuxG),
    .ShiftRightAmount(ShiftRightAmount), .Pipe0En(Pipe0En), .Pipe1En(Pipe1En),
    .NormEn(NormEn), .SelManMuxR(SelManMuxR), .SelExpMuxR(SelExpMuxR), .SREn(SREn),
    .Busy(Busy), .Done(Done), .Zero(Zero), .Inf(Inf), .Nan(Nan)
  );

  always #5 Clock = ~Clock;

  wire [20:0] w_allout = {SelExpMux, SelSRMuxL, SelSRMuxG, ShiftRightAmount, Pipe0En,
                          Pipe1En, NormEn, SelManMuxR, SelExpMuxR, SREn, Busy, Done,
                          Zero, Inf, Nan};

  typedef struct {
    logic       sa, sb;
    logic [7:0] ea, eb;
    logic       fa, fb, eset;
    logic [7:0] ediff;
    logic       carry, szero, rovf, eovf;
    logic [5:0] x_sh;
    logic       x_selexp, x_srl, x_srg, x_sren;
    int         x_lat;
    logic [2:0] x_flags;  // {Zero, Inf, Nan}
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic vec_t mk(input logic sa, sb, input int ea, eb, input logic fa, fb, eset,
                              input int ediff, input logic carry, szero, rovf, eovf,
                              input int sh, input logic selexp, srl, srg, sren,
                              input int lat, input logic [2:0] flags);
    vec_t v;
    v.sa = sa; v.sb = sb; v.ea = 8'(ea); v.eb = 8'(eb); v.fa = fa; v.fb = fb;
    v.eset = eset; v.ediff = 8'(ediff); v.carry = carry; v.szero = szero;
    v.rovf = rovf; v.eovf = eovf; v.x_sh = 6'(sh); v.x_selexp = selexp;
    v.x_srl = srl; v.x_srg = srg; v.x_sren = sren; v.x_lat = lat; v.x_flags = flags;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    SignA = v.sa; SignB = v.sb; ExpA = v.ea; ExpB = v.eb; FracANz = v.fa; FracBNz = v.fb;
    ExpSet = v.eset; ExpDiff = v.ediff; SumCarry = v.carry; SumZero = v.szero;
    RoundOvf = v.rovf; ExpOvf = v.eovf;
  endtask

  // Apply one operation from IDLE and follow it to completion
  task automatic run_op(input int idx, input vec_t v);
    int  cnt;
    bit  seen_p1, first_norm;
    @(negedge Clock);
    drive(v);
    Go = 1'b1;
    #1;
    chk($sformatf("v%0d_pipe0en", idx), int'(Pipe0En), 1);
    chk($sformatf("v%0d_shamt", idx), int'(ShiftRightAmount), int'(v.x_sh));
    chk($sformatf("v%0d_sels", idx), int'({SelExpMux, SelSRMuxL, SelSRMuxG}),
        int'({v.x_selexp, v.x_srl, v.x_srg}));
    chk($sformatf("v%0d_idle_busy", idx), int'(Busy), 0);
    @(posedge Clock); #1;
    Go = 1'b0;
    cnt = 1; seen_p1 = 0; first_norm = 1;
    if (v.x_lat != 1) chk($sformatf("v%0d_flags_clr", idx), int'({Zero, Inf, Nan}), 0);
    while (!Done && cnt < 12) begin
      if (Pipe1En) seen_p1 = 1;
      if (NormEn && first_norm) begin
        chk($sformatf("v%0d_sren", idx), int'(SREn), int'(v.x_sren));
        first_norm = 0;
      end
      @(posedge Clock); #1;
      cnt++;
    end
    chk($sformatf("v%0d_latency", idx), cnt, v.x_lat);
    chk($sformatf("v%0d_flags", idx), int'({Zero, Inf, Nan}), int'(v.x_flags));
    chk($sformatf("v%0d_pipe1_seen", idx), int'(seen_p1), (v.x_lat == 1) ? 0 : 1);
    @(posedge Clock); #1;
    chk($sformatf("v%0d_after_done", idx), int'({Busy, Done}), 0);
    chk($sformatf("v%0d_flags_hold", idx), int'({Zero, Inf, Nan}), int'(v.x_flags));
  endtask

  initial begin
    int cnt;
    //                 sa sb  ea   eb  fa fb es  dif  cy sz ro eo   sh se sl sg sr lat flags
    vecs[0]  = mk(0, 0, 127, 127, 0, 0, 1,   0, 1, 0, 0, 0,  0, 1, 0, 1, 1, 4, 3'b000); // 1+1
    vecs[1]  = mk(0, 0, 127,  87, 0, 0, 1,  40, 0, 0, 0, 0, 26, 1, 0, 1, 0, 4, 3'b000); // 1+2^-40
    vecs[2]  = mk(0, 0,  87, 127, 0, 0, 0,  40, 0, 0, 0, 0, 26, 0, 1, 0, 0, 4, 3'b000); // swapped
    vecs[3]  = mk(0, 0, 127, 101, 0, 0, 1,  26, 0, 0, 0, 0, 26, 1, 0, 1, 0, 4, 3'b000); // diff=sat
    vecs[4]  = mk(0, 0, 127, 102, 0, 0, 1,  25, 0, 0, 0, 0, 25, 1, 0, 1, 0, 4, 3'b000); // below sat
    vecs[5]  = mk(0, 1, 255, 255, 0, 0, 1,   0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 1, 3'b001); // +Inf + -Inf
    vecs[6]  = mk(0, 0, 255, 127, 1, 0, 1, 128, 0, 0, 0, 0, 26, 1, 0, 1, 0, 1, 3'b001); // NaN + 1
    vecs[7]  = mk(0, 0, 255, 255, 0, 0, 1,   0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 1, 3'b010); // +Inf + +Inf
    vecs[8]  = mk(1, 0, 255, 130, 0, 1, 1, 125, 0, 0, 0, 0, 26, 1, 0, 1, 0, 1, 3'b010); // -Inf + x
    vecs[9]  = mk(0, 1,   0,   0, 0, 0, 1,   0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 1, 3'b100); // 0 + -0
    vecs[10] = mk(0, 1, 127, 127, 0, 0, 1,   0, 0, 1, 0, 0,  0, 1, 0, 1, 0, 3, 3'b100); // 1 + -1
    vecs[11] = mk(0, 0, 254, 254, 1, 1, 1,   0, 1, 0, 0, 1,  0, 1, 0, 1, 1, 4, 3'b010); // max+max
    vecs[12] = mk(0, 0,   0, 127, 0, 0, 0, 127, 0, 0, 0, 0, 26, 0, 1, 0, 0, 4, 3'b000); // 0 + 1
    vecs[13] = mk(0, 0, 127, 127, 0, 0, 1,   0, 0, 0, 1, 0,  0, 1, 0, 1, 0, 6, 3'b000); // renorm
    vecs[14] = mk(0, 0, 255, 255, 0, 1, 1,   0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 1, 3'b001); // Inf + NaN

    // Reset state
    #1;
    chk("reset_outputs", int'(w_allout), 0);
    @(negedge Clock); @(negedge Clock);
    Reset_n = 1'b1;
    #1;
    chk("post_reset_idle", int'(w_allout), 0);

    for (int i = 0; i < 15; i++) run_op(i, vecs[i]);

    // Re-normalization pass, cycle by cycle
    @(negedge Clock);
    drive(vecs[13]);
    Go = 1'b1;
    @(posedge Clock); #1; Go = 1'b0;                       // ADD
    chk("rn_add_ctl", int'({Pipe1En, SelManMuxR, SelExpMuxR}), 3'b100);
    @(posedge Clock); #1;                                   // NORM 1
    chk("rn_norm1", int'({NormEn, SREn}), 2'b10);
    @(posedge Clock); #1;                                   // ROUND 1
    chk("rn_round1", int'({SelManMuxR, SelExpMuxR, Pipe1En, Done}), 4'b1110);
    @(posedge Clock); #1;                                   // NORM 2
    chk("rn_norm2", int'({NormEn, SREn, SelManMuxR}), 3'b110);
    @(posedge Clock); #1;                                   // ROUND 2, RoundOvf ignored
    chk("rn_round2", int'({SelManMuxR, SelExpMuxR, Pipe1En, NormEn, Done}), 0);
    @(posedge Clock); #1;
    chk("rn_done", int'({Done, Busy}), 2'b11);
    @(posedge Clock); #1;
    chk("rn_idle", int'({Done, Busy}), 0);

    // Go pulsed during ADD is ignored
    @(negedge Clock);
    drive(vecs[0]);
    Go = 1'b1;
    @(posedge Clock); #1;                                   // ADD, Go still high
    chk("gob_add_busy", int'(Busy), 1);
    @(posedge Clock); #1; Go = 1'b0;                        // NORM
    chk("gob_norm", int'({Busy, NormEn, Pipe0En}), 3'b110);
    cnt = 2;
    while (!Done && cnt < 12) begin @(posedge Clock); #1; cnt++; end
    chk("gob_latency", cnt, 4);
    @(posedge Clock); #1;
    chk("gob_no_restart", int'(Busy), 0);

    // Reset during NORM discards the operation
    @(negedge Clock);
    drive(vecs[0]);
    Go = 1'b1;
    @(posedge Clock); #1; Go = 1'b0;
    @(posedge Clock); #1;                                   // NORM, SREn=1
    chk("rst_pre_norm", int'({NormEn, SREn}), 2'b11);
    Reset_n = 1'b0;
    #1;
    chk("rst_async_outputs", int'(w_allout), 0);
    @(negedge Clock); @(negedge Clock);
    Reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin @(posedge Clock); #1; if (Done || Busy) cnt++; end
    chk("rst_no_done", cnt, 0);
    run_op(100, vecs[1]);

    // Go held high: one operation per 5 cycles
    @(negedge Clock);
    drive(vecs[1]);
    Go = 1'b1;
    cnt = 0;
    @(posedge Clock); #1;
    while (!Done && cnt < 12) begin @(posedge Clock); #1; cnt++; end
    cnt = 0;
    @(posedge Clock); #1;
    cnt = 1;
    while (!Done && cnt < 12) begin @(posedge Clock); #1; cnt++; end
    chk("b2b_period", cnt, 5);
    Go = 1'b0;
    cnt = 0;
    while (Busy && cnt < 12) begin @(posedge Clock); #1; cnt++; end
    chk("b2b_drain_idle", int'(Busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
